// File: rtl/wb_seq_ctrl.sv
// Load/store/writeback sequencer: IDLE -> (MEM) -> WB, with req/ready memory handshake.
// Optional memory-timeout abort is compiled in with `define WB_TIMEOUT_EN.
module wb_seq_ctrl #(
    parameter int DW             = 32,
    parameter int AW             = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] alu_q,
    output logic [DW-1:0] mem_q,
    output logic          wb_sel,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic          instr_done,
    output logic          err
);

    // state  | meaning
    // S_IDLE | waiting for an instruction, instr_ready high
    // S_MEM  | memory request outstanding until mem_ready (or timeout)
    // S_WB   | single writeback cycle, instr_done pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] mdata_q, mdata_d;
    logic          load_q, load_d;
    logic          store_q, store_d;
    logic          sel_q, sel_d;
    logic          accept;

`ifdef WB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;
`endif

    assign accept = instr_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdata_d = mdata_q;
        load_d  = load_q;
        store_d = store_q;
        sel_d   = sel_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = tout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    waddr_d = rd;
                    addr_d  = alu_result;
                    wdata_d = store_data;
                    load_d  = is_load;
                    store_d = is_store && !is_load;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    tout_d  = 1'b0;
`endif
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                        sel_d   = 1'b0;
                    end
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                    sel_d   = load_q;
                    if (load_q) mdata_d = mem_rdata;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_WB;
                    sel_d   = load_q;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            waddr_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdata_q <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdata_q <= mdata_d;
            load_q  <= load_d;
            store_q <= store_d;
            sel_q   <= sel_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end
    assign err = (state_q == S_WB) && tout_q;
`else
    assign err = 1'b0;
`endif

    // Outputs decode straight from state so reset removes mem_req without a clock.
    assign instr_ready = (state_q == S_IDLE);
    assign mem_req     = (state_q == S_MEM);
    assign mem_we      = (state_q == S_MEM) && store_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign alu_q       = addr_q;
    assign mem_q       = mdata_q;
    assign wb_sel      = sel_q;
    assign rf_waddr    = waddr_q;
    assign instr_done  = (state_q == S_WB);
    assign rf_we       = (state_q == S_WB) && !store_q && !err && (waddr_q != '0);

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Bench for wb_seq_ctrl: directed cases plus randomized instruction stream against a transaction model.
module tb_wb_seq_ctrl;

`ifdef WB_TIMEOUT_EN
    localparam int TB_TO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] alu_q, mem_q;
    logic        wb_sel, rf_we;
    logic [4:0]  rf_waddr;
    logic        instr_done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    bit mon_en  = 1'b0;
    bit rf_we_seen = 1'b0;

    // reference state: what the writeback-side registers should hold
    logic [31:0] mem_q_m = '0;
    logic        wb_sel_m = 1'b0;

    wb_seq_ctrl #(.DW(32), .AW(5), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .is_load(is_load), .is_store(is_store), .rd(rd),
        .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .alu_q(alu_q), .mem_q(mem_q), .wb_sel(wb_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .instr_done(instr_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mon_en && rf_we) rf_we_seen <= 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("ready_wait", {31'd0, instr_ready}, 32'd1);
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. delay = MEM cycle on which mem_ready is given.
    task automatic run_instr(input int kind, input logic [4:0] r, input logic [31:0] a,
                             input logic [31:0] sd, input int delay, input logic [31:0] rdata);
        bit tout = 1'b0;
        bit exp_we;
        wait_ready();
        instr_valid = 1'b1;
        is_load     = (kind == 1);
        is_store    = (kind == 2) || (kind == 1 && $urandom_range(0, 1) == 1);
        rd          = r;
        alu_result  = a;
        store_data  = sd;
        mem_ready   = $urandom_range(0, 1) == 1;
        mem_rdata   = $urandom;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        instr_valid = 1'b0;
        is_load     = $urandom_range(0, 1) == 1;
        is_store    = $urandom_range(0, 1) == 1;
        rd          = 5'($urandom);
        alu_result  = $urandom;
        store_data  = $urandom;
        mem_ready   = 1'b0;
        check("busy_not_ready", {31'd0, instr_ready}, 32'd0);
        if (kind != 0) begin
            for (int i = 1; i <= 64; i++) begin
                bit last;
                check("mem_req", {31'd0, mem_req}, 32'd1);
                check("mem_we", {31'd0, mem_we}, {31'd0, kind == 2});
                check("mem_addr", mem_addr, a);
                if (kind == 2) check("mem_wdata", mem_wdata, sd);
                last      = (i == delay) || (TO_EN && i == TB_TO);
                mem_ready = (i == delay);
                mem_rdata = (i == delay) ? rdata : $urandom;
                @(posedge clk);
                @(negedge clk);
                if (last) begin
                    tout = (i != delay);
                    break;
                end
            end
            mem_ready = 1'b0;
        end
        if (kind == 1 && !tout) mem_q_m = rdata;
        wb_sel_m = (kind == 1);
        exp_we   = !tout && kind != 2 && r != 5'd0;
        check("wb_done", {31'd0, instr_done}, 32'd1);
        check("wb_rf_we", {31'd0, rf_we}, {31'd0, exp_we});
        check("wb_err", {31'd0, err}, {31'd0, tout});
        check("wb_waddr", {27'd0, rf_waddr}, {27'd0, r});
        check("wb_sel", {31'd0, wb_sel}, {31'd0, wb_sel_m});
        check("wb_alu_q", alu_q, a);
        check("wb_mem_q", mem_q, mem_q_m);
        check("wb_no_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_done", {31'd0, instr_done}, 32'd0);
        check("post_rf_we", {31'd0, rf_we}, 32'd0);
        check("post_ready", {31'd0, instr_ready}, 32'd1);
        check("post_sel_hold", {31'd0, wb_sel}, {31'd0, wb_sel_m});
    endtask

    initial begin
        int prev_acc;
        #3;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_done", {31'd0, instr_done}, 32'd0);
        check("rst_alu_q", alu_q, 32'd0);
        check("rst_mem_q", mem_q, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_sel", {31'd0, wb_sel}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_instr(0, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
        run_instr(1, 5'd3, 32'h40, 32'h0, 3, 32'hDEADBEEF);
        run_instr(2, 5'd9, 32'h80, 32'hCAFE, 1, 32'h0);
        run_instr(0, 5'd0, 32'h55, 32'h0, 0, 32'h0);
        prev_acc = acc_cyc;
        run_instr(0, 5'd7, 32'h66, 32'h0, 0, 32'h0);
        check("b2b_gap", 32'(acc_cyc - prev_acc), 32'd2);
        run_instr(1, 5'd0, 32'h44, 32'h0, 2, 32'h12345678);

        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 2);
            logic [4:0] r = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            run_instr(kind, r, $urandom, $urandom, $urandom_range(1, 6), $urandom);
        end

        // reset while a load is in MEM
        wait_ready();
        instr_valid = 1'b1;
        is_load = 1'b1;
        is_store = 1'b0;
        rd = 5'd7;
        alu_result = 32'h100;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'd0, mem_req}, 32'd0);
        check("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        mem_q_m = '0;
        wb_sel_m = 1'b0;
        check("rst_mid_no_rf_we", {31'd0, rf_we_seen}, 32'd0);
        check("rst_mid_ready_after", {31'd0, instr_ready}, 32'd1);
        check("rst_mid_mem_q", mem_q, 32'd0);
        check("rst_mid_alu_q", alu_q, 32'd0);
        mon_en = 1'b0;

        run_instr(1, 5'd12, 32'h200, 32'h0, 1, 32'hA5A5A5A5);
        if (TO_EN) begin
            run_instr(1, 5'd4, 32'h300, 32'h0, TB_TO + 3, 32'h11111111);
            run_instr(1, 5'd4, 32'h304, 32'h0, TB_TO, 32'h22222222);
            run_instr(2, 5'd4, 32'h308, 32'h5A5A, TB_TO + 1, 32'h0);
        end else begin
            run_instr(1, 5'd4, 32'h300, 32'h0, 20, 32'h33333333);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
